// File: rtl/axi4lite_pkg.sv
// ============================================================================
// Module      : axi4lite_pkg
// Description : Shared AXI4-Lite response codes, access sizes and LSU states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/axi4lite_lane_align.sv
// ============================================================================
// Module      : axi4lite_lane_align
// Description : Byte-lane strobe/data steering, load extraction, alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_lane_align
    import axi4lite_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    input  logic        load_unsigned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata_in >> {off, 3'b000};
        wstrb      = 4'b0000;
        wdata_out  = wdata_in;
        rdata_out  = rdata_in;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wstrb     = 4'b0001 << off;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = load_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wstrb      = 4'b0011 << off;
                wdata_out  = {2{wdata_in[15:0]}};
                rdata_out  = load_unsigned ? {16'd0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
                misaligned = off[0];
            end
            SZ_WORD: begin
                wstrb      = 4'b1111;
                misaligned = (off != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi4lite_master_lsu.sv
// ============================================================================
// Module      : axi4lite_master_lsu
// Description : CPU load/store port to single-beat AXI4-Lite master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4lite_master_lsu
    import axi4lite_pkg::*;
#(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDRESS-1:0]    cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic [1:0]            cpu_size_i,
    input  logic                  cpu_unsigned_i,
    output logic                  cpu_ready_o,
    output logic                  cpu_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_err_o,
    output logic [ADDRESS-1:0]    M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDRESS-1:0]    M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    state_e                state_q, state_d;
    logic [ADDRESS-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  aw_valid_q, w_valid_q, ar_valid_q;

    logic [1:0]            al_off, al_size;
    logic [3:0]            al_wstrb;
    logic [31:0]           al_wdata, al_rdata;
    logic                  al_misaligned;

    // Aligner sees the live CPU request in IDLE and the latched one afterwards
    assign al_off  = (state_q == ST_IDLE) ? cpu_addr_i[1:0] : addr_q[1:0];
    assign al_size = (state_q == ST_IDLE) ? cpu_size_i      : size_q;

    axi4lite_lane_align u_align (
        .off           (al_off),
        .size          (al_size),
        .wdata_in      (cpu_wdata_i),
        .rdata_in      (M_RDATA),
        .load_unsigned (unsigned_q),
        .wstrb         (al_wstrb),
        .wdata_out     (al_wdata),
        .rdata_out     (al_rdata),
        .misaligned    (al_misaligned)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cpu_ready_o     = 1'b0;
        cpu_rsp_valid_o = 1'b0;
        cpu_err_o       = 1'b0;
        M_BREADY        = 1'b0;
        M_RREADY        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_ready_o = !ARESET;
                if (cpu_req_i) begin
                    if (al_misaligned) state_d = ST_ERR;
                    else if (cpu_we_i) state_d = ST_WRITE;
                    else               state_d = ST_RADDR;
                end
            end
            ST_WRITE: begin
                // AW and W may complete together or in either order
                if ((!aw_valid_q || M_AWREADY) && (!w_valid_q || M_WREADY))
                    state_d = ST_WRESP;
            end
            ST_WRESP: begin
                M_BREADY = 1'b1;
                if (M_BVALID) state_d = ST_RESP;
            end
            ST_RADDR: begin
                if (M_ARREADY) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                M_RREADY = 1'b1;
                if (M_RVALID) state_d = ST_RESP;
            end
            ST_RESP: begin
                cpu_rsp_valid_o = 1'b1;
                cpu_err_o       = err_q;
                state_d         = ST_IDLE;
            end
            ST_ERR: begin
                cpu_rsp_valid_o = 1'b1;
                cpu_err_o       = 1'b1;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        addr_q     <= cpu_addr_i;
                        wdata_q    <= al_wdata;
                        wstrb_q    <= al_wstrb;
                        size_q     <= cpu_size_i;
                        unsigned_q <= cpu_unsigned_i;
                        err_q      <= 1'b0;
                        if (al_misaligned) begin
                            rdata_q <= '0;
                        end else if (cpu_we_i) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                        end else begin
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (aw_valid_q && M_AWREADY) aw_valid_q <= 1'b0;
                    if (w_valid_q && M_WREADY)   w_valid_q  <= 1'b0;
                end
                ST_WRESP: begin
                    if (M_BVALID) begin
                        err_q   <= (M_BRESP != RESP_OKAY);
                        rdata_q <= '0;
                    end
                end
                ST_RADDR: begin
                    if (M_ARREADY) ar_valid_q <= 1'b0;
                end
                ST_RDATA: begin
                    if (M_RVALID) begin
                        err_q   <= (M_RRESP != RESP_OKAY);
                        rdata_q <= al_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign M_AWADDR    = addr_q;
    assign M_ARADDR    = addr_q;
    assign M_WDATA     = wdata_q;
    assign M_WSTRB     = wstrb_q;
    assign M_AWVALID   = aw_valid_q;
    assign M_WVALID    = w_valid_q;
    assign M_ARVALID   = ar_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_master_lsu.sv
// ============================================================================
// Module      : tb_axi4lite_master_lsu
// Description : Directed bench with AXI4-Lite slave model and response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4lite_master_lsu;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cpu_req_i, cpu_we_i, cpu_unsigned_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic [1:0]  cpu_size_i;
    logic        cpu_ready_o, cpu_rsp_valid_o, cpu_err_o;
    logic [31:0] cpu_rdata_o;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    axi4lite_master_lsu dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_size_i(cpu_size_i), .cpu_unsigned_i(cpu_unsigned_i),
        .cpu_ready_o(cpu_ready_o), .cpu_rsp_valid_o(cpu_rsp_valid_o),
        .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    int          aw_lat, w_lat;
    logic        r_block;
    logic [1:0]  b_resp_cfg, r_resp_cfg;
    logic [31:0] r_data_cfg;
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got, bvalid_r, rvalid_r;
    logic [31:0] last_awaddr, last_wdata, last_araddr;
    logic [3:0]  last_wstrb;

    assign M_AWREADY = M_AWVALID && (aw_cnt >= aw_lat);
    assign M_WREADY  = M_WVALID && (w_cnt >= w_lat);
    assign M_ARREADY = M_ARVALID;
    assign M_BVALID  = bvalid_r;
    assign M_BRESP   = b_resp_cfg;
    assign M_RVALID  = rvalid_r && !r_block;
    assign M_RDATA   = r_data_cfg;
    assign M_RRESP   = r_resp_cfg;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0;
        end else begin
            aw_cnt <= (M_AWVALID && !M_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_WVALID && !M_WREADY) ? w_cnt + 1 : 0;
            if (M_AWVALID && M_AWREADY) begin aw_got <= 1'b1; last_awaddr <= M_AWADDR; end
            if (M_WVALID && M_WREADY) begin
                w_got <= 1'b1; last_wdata <= M_WDATA; last_wstrb <= M_WSTRB;
            end
            if (bvalid_r && M_BREADY) begin
                bvalid_r <= 1'b0;
            end else if ((aw_got || (M_AWVALID && M_AWREADY)) &&
                         (w_got || (M_WVALID && M_WREADY)) && !bvalid_r) begin
                bvalid_r <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (M_ARVALID && M_ARREADY) last_araddr <= M_ARADDR;
            if (M_RVALID && M_RREADY) rvalid_r <= 1'b0;
            else if (M_ARVALID && M_ARREADY) rvalid_r <= 1'b1;
        end
    end

    // ---------------- activity monitors ----------------
    int cyc = 0, pulses = 0, aw_cycles = 0, w_cycles = 0, bus_cycles = 0, b_hs = 0;
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (cpu_rsp_valid_o) pulses <= pulses + 1;
        if (M_AWVALID) aw_cycles <= aw_cycles + 1;
        if (M_WVALID) w_cycles <= w_cycles + 1;
        if (M_AWVALID || M_WVALID || M_ARVALID) bus_cycles <= bus_cycles + 1;
        if (M_BVALID && M_BREADY) b_hs <= b_hs + 1;
    end

    // ---------------- scoreboard and checks ----------------
    typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   acc_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns);
        @(negedge ACLK);
        check("ready_idle", {31'd0, cpu_ready_o}, 32'd1);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
        cpu_size_i = sz; cpu_unsigned_i = uns;
        acc_cyc = cyc;
        @(negedge ACLK);
        cpu_req_i = 1'b0;
        check("ready_busy", {31'd0, cpu_ready_o}, 32'd0);
    endtask

    task automatic wait_rsp(input string tag, input int lat);
        exp_t e;
        int   i;
        for (i = 0; i < 60 && !cpu_rsp_valid_o; i++) @(negedge ACLK);
        check({tag, "_pulse"}, {31'd0, cpu_rsp_valid_o}, 32'd1);
        check({tag, "_lat"}, cyc - acc_cyc, lat);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, cpu_rdata_o, e.rdata);
            check({tag, "_err"}, {31'd0, cpu_err_o}, {31'd0, e.err});
        end
        check({tag, "_ready_pulse"}, {31'd0, cpu_ready_o}, 32'd0);
        @(negedge ACLK);
        check({tag, "_pulse_one"}, {31'd0, cpu_rsp_valid_o}, 32'd0);
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] expd, input logic experr);
        exp_q.push_back('{expd, experr});
        issue(1'b0, addr, 32'h0, sz, uns);
        wait_rsp(tag, 3);
        check({tag, "_araddr"}, last_araddr, addr);
    endtask

    int snap_aw, snap_w, snap_bus, snap_b, snap_p;
    logic [10:0] outs;

    initial begin
        ARESET = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0;
        cpu_wdata_i = '0; cpu_size_i = 2'b00; cpu_unsigned_i = 1'b0;
        aw_lat = 0; w_lat = 0; r_block = 1'b0;
        b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = 32'h80FF7F01;
        repeat (3) @(negedge ACLK);
        outs = {cpu_ready_o, cpu_rsp_valid_o, cpu_err_o, M_AWVALID, M_WVALID,
                M_BREADY, M_ARVALID, M_RREADY, 3'b000};
        check("reset_ctrl", {21'd0, outs}, 32'd0);
        check("reset_rdata", cpu_rdata_o, 32'd0);
        check("reset_awaddr", M_AWADDR, 32'd0);
        ARESET = 1'b0;

        // word store, zero-wait
        exp_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        wait_rsp("st_word", 3);
        check("st_word_awaddr", last_awaddr, 32'h10);
        check("st_word_wstrb", {28'd0, last_wstrb}, 32'hF);
        check("st_word_wdata", last_wdata, 32'hDEADBEEF);

        // byte store, AW accepted 3 cycles ahead of W
        aw_lat = 0; w_lat = 3;
        snap_aw = aw_cycles; snap_w = w_cycles; snap_b = b_hs;
        exp_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 32'h13, 32'h000000A5, 2'b00, 1'b0);
        wait_rsp("st_byte", 6);
        check("st_byte_wstrb", {28'd0, last_wstrb}, 32'h8);
        check("st_byte_wdata", last_wdata, 32'hA5A5A5A5);
        check("st_byte_awaddr", last_awaddr, 32'h13);
        check("st_byte_aw_cycles", aw_cycles - snap_aw, 1);
        check("st_byte_w_cycles", w_cycles - snap_w, 4);
        check("st_byte_b_hs", b_hs - snap_b, 1);
        w_lat = 0;

        // half store at +2
        exp_q.push_back('{32'h0, 1'b0});
        issue(1'b1, 32'h22, 32'h00001234, 2'b01, 1'b0);
        wait_rsp("st_half", 3);
        check("st_half_wstrb", {28'd0, last_wstrb}, 32'hC);
        check("st_half_wdata", last_wdata, 32'h12341234);

        // loads of 0x80FF7F01
        load("ld_sb3", 32'h23, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        load("ld_uh2", 32'h22, 2'b01, 1'b1, 32'h000080FF, 1'b0);
        load("ld_sh0", 32'h20, 2'b01, 1'b0, 32'h00007F01, 1'b0);
        load("ld_word", 32'h20, 2'b10, 1'b0, 32'h80FF7F01, 1'b0);
        load("ld_ub1", 32'h21, 2'b00, 1'b1, 32'h0000007F, 1'b0);

        // misaligned word load and illegal-size store
        snap_bus = bus_cycles;
        exp_q.push_back('{32'h0, 1'b1});
        issue(1'b0, 32'h6, 32'h0, 2'b10, 1'b0);
        wait_rsp("mis_word", 1);
        exp_q.push_back('{32'h0, 1'b1});
        issue(1'b1, 32'h8, 32'h11223344, 2'b11, 1'b0);
        wait_rsp("bad_size", 1);
        check("mis_no_bus", bus_cycles - snap_bus, 0);

        // slave error responses
        b_resp_cfg = 2'b10;
        exp_q.push_back('{32'h0, 1'b1});
        issue(1'b1, 32'h30, 32'hCAFEF00D, 2'b10, 1'b0);
        wait_rsp("st_slverr", 3);
        b_resp_cfg = 2'b00;
        r_resp_cfg = 2'b10; r_data_cfg = 32'h12345678;
        load("ld_slverr", 32'h31, 2'b00, 1'b0, 32'h00000056, 1'b1);
        r_resp_cfg = 2'b00; r_data_cfg = 32'h80FF7F01;

        // reset while waiting for read data
        snap_p = pulses;
        r_block = 1'b1;
        issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
        @(negedge ACLK);
        check("rst_pre_rready", {31'd0, M_RREADY}, 32'd1);
        #2 ARESET = 1'b1;
        #1;
        outs = {cpu_ready_o, cpu_rsp_valid_o, cpu_err_o, M_AWVALID, M_WVALID,
                M_BREADY, M_ARVALID, M_RREADY, 3'b000};
        check("async_rst_ctrl", {21'd0, outs}, 32'd0);
        check("async_rst_araddr", M_ARADDR, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0; r_block = 1'b0;
        repeat (2) @(negedge ACLK);
        check("rst_no_stale", pulses - snap_p, 0);
        load("ld_after_rst", 32'h42, 2'b00, 1'b1, 32'h000000FF, 1'b0);
        check("rst_pulse_total", pulses - snap_p, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
